// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises a raw bouncing button, debounces it and
// derives a clean level, press/release/long-press pulses and a press-toggled level.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000,
  parameter bit          ACTIVE_LOW_BTN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic       toggle,
  output logic [1:0] dbg_state
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (LONG_PRESS_CYCLES < 1) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $fatal(1, "button_debouncer: DEBOUNCE_CYCLES must be nonzero");
  end
  if (LONG_PRESS_CYCLES == 0) begin : g_bad_long_press
    $fatal(1, "button_debouncer: LONG_PRESS_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [1:0]    sync;
  logic          btn_s;
  logic          commit_press, commit_release, long_fire;
  logic          level_nxt, toggle_nxt;

  // Flops reset to the idle raw level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= {2{ACTIVE_LOW_BTN}};
    end else begin
      sync <= {sync[0], btn_in};
    end
  end

  assign btn_s     = sync[1] ^ ACTIVE_LOW_BTN;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      hcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      hcnt          <= hcnt_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= commit_press;
      release_pulse <= commit_release;
      long_press    <= long_fire;
      toggle        <= toggle_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hcnt_nxt       = hcnt;
    commit_press   = 1'b0;
    commit_release = 1'b0;
    long_fire      = 1'b0;

    // Hold time runs through release debouncing; saturation makes long_press one-shot.
    if ((state == PRESSED || state == RELEASE_WAIT) && hcnt != HOLD_MAX) begin
      hcnt_nxt  = hcnt + HW'(1);
      long_fire = (hcnt == HOLD_LAST);
    end

    case (state)
      RELEASED: begin
        if (btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt    = PRESSED;
            cnt_nxt      = '0;
            commit_press = 1'b1;
          end else begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = PRESSED;
          cnt_nxt      = '0;
          commit_press = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt      = RELEASED;
            cnt_nxt        = '0;
            commit_release = 1'b1;
          end else begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt      = RELEASED;
          cnt_nxt        = '0;
          commit_release = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase

    if (commit_press) begin
      hcnt_nxt = '0;
    end
  end

  always_comb begin
    level_nxt = btn_level;
    if (commit_press) begin
      level_nxt = 1'b1;
    end else if (commit_release) begin
      level_nxt = 1'b0;
    end
    toggle_nxt = toggle ^ commit_press;
  end

endmodule
